// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and retires BITS_PER_CYCLE
// result bits per iteration, so a normal op takes DATA_WIDTH/BITS_PER_CYCLE + 1 cycles.
// Divide-by-zero and signed overflow finish one cycle after acceptance.
// Optional build macro MULDIV_REUSE_EN adds a last-operation cache. With the
// cache, a MULH* after a MUL of the same operands and signedness class, or a
// REM after a DIV (or the reverse), finishes one cycle after acceptance.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, op            request and funct3 opcode, accepted when in_ready=1
//   operand_a, operand_b rs1 / rs2 values
//   flush                abort the op in flight and return to IDLE
//   in_ready             unit can accept a request this cycle
//   busy                 stall request to the execute stage
//   done, result         one-cycle completion pulse; result held until next completion
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | iterating, count = iterations already performed
// DONE  | done pulse cycle, a new start may be accepted here
module muldiv_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  flush,
   output logic                  in_ready,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int W  = DATA_WIDTH;
   localparam int B  = BITS_PER_CYCLE;
   localparam int N  = W / B;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state;
   logic [2:0]     op_r;
   logic           sa_r, sb_r;
   logic [W-1:0]   b_mag;
   // multiply: product register; divide: {remainder, quotient/dividend}
   logic [2*W-1:0] acc;
   logic [CW-1:0]  count;
   logic           done_r;
   logic [W-1:0]   result_r;

   assign in_ready = (state == IDLE) || (state == DONE);
   assign busy     = (state == BUSY) || start;
   assign done     = done_r;
   assign result   = result_r;

   function automatic logic [W-1:0] pick(input logic [2:0] o, input logic [2*W-1:0] v);
      if (o[2]) pick = o[1] ? v[2*W-1:W] : v[W-1:0];
      else      pick = (o[1:0] == 2'b00) ? v[W-1:0] : v[2*W-1:W];
   endfunction

   // Request decode
   logic           a_neg, b_neg, div_zero, div_ovf, special;
   logic [W-1:0]   a_mag, b_mag_in;
   logic [2*W-1:0] special_val;

   always_comb begin
      a_neg       = ((op == 3'b001) || (op == 3'b010) || (op[2] && !op[0])) && operand_a[W-1];
      b_neg       = ((op == 3'b001) || (op[2] && !op[0])) && operand_b[W-1];
      a_mag       = a_neg ? -operand_a : operand_a;
      b_mag_in    = b_neg ? -operand_b : operand_b;
      div_zero    = op[2] && (operand_b == '0);
      div_ovf     = op[2] && !op[0] && (operand_a == {1'b1, {(W-1){1'b0}}}) && (operand_b == '1);
      special     = div_zero || div_ovf;
      special_val = div_zero ? {operand_a, {W{1'b1}}} : {{W{1'b0}}, operand_a};
   end

   // One iteration of shift-add multiply or restoring divide
   logic [B-1:0]   digit;
   logic [W+B-1:0] sum;
   logic [W:0]     trial;
   logic [W-1:0]   rem_v, quo_v, q_fix, r_fix;
   logic [2*W-1:0] step, fin;

   always_comb begin
      digit = acc[B-1:0];
      sum   = {{B{1'b0}}, acc[2*W-1:W]} + ({{B{1'b0}}, b_mag} * {{W{1'b0}}, digit});
      rem_v = acc[2*W-1:W];
      quo_v = acc[W-1:0];
      trial = '0;
      for (int i = 0; i < B; i++) begin
         trial = {rem_v, quo_v[W-1]};
         quo_v = {quo_v[W-2:0], 1'b0};
         if (trial >= {1'b0, b_mag}) begin
            trial    = trial - {1'b0, b_mag};
            quo_v[0] = 1'b1;
         end
         rem_v = trial[W-1:0];
      end
      step = op_r[2] ? {rem_v, quo_v} : {sum, acc[W-1:B]};

      // signs are applied only on the last iteration
      q_fix = (sa_r ^ sb_r) ? -step[W-1:0] : step[W-1:0];
      r_fix = sa_r ? -step[2*W-1:W] : step[2*W-1:W];
      if (op_r[2])            fin = {r_fix, q_fix};
      else if (sa_r ^ sb_r)   fin = -step;
      else                    fin = step;
   end

`ifdef MULDIV_REUSE_EN
   // class: same value means the cached full result answers both ops
   function automatic logic [2:0] cls_of(input logic [2:0] o);
      if (o[2])                    cls_of = {2'b10, o[0]};
      else if (o[1:0] == 2'b00)    cls_of = 3'b011;
      else                         cls_of = {1'b0, o[1:0]};
   endfunction

   logic [W-1:0]   a_r, b_r, cache_a, cache_b;
   logic [2:0]     cache_cls;
   logic [2*W-1:0] cache_val;
   logic           cache_valid, hit;

   assign hit = cache_valid && (cache_a == operand_a) && (cache_b == operand_b)
                && (cache_cls == cls_of(op));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_r     <= '0;
         sa_r     <= 1'b0;
         sb_r     <= 1'b0;
         b_mag    <= '0;
         acc      <= '0;
         count    <= '0;
         done_r   <= 1'b0;
         result_r <= '0;
`ifdef MULDIV_REUSE_EN
         a_r         <= '0;
         b_r         <= '0;
         cache_a     <= '0;
         cache_b     <= '0;
         cache_cls   <= '0;
         cache_val   <= '0;
         cache_valid <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if (flush) begin
            state <= IDLE;
`ifdef MULDIV_REUSE_EN
            cache_valid <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     op_r  <= op;
                     sa_r  <= a_neg;
                     sb_r  <= b_neg;
                     b_mag <= b_mag_in;
                     acc   <= {{W{1'b0}}, a_mag};
                     count <= '0;
`ifdef MULDIV_REUSE_EN
                     a_r <= operand_a;
                     b_r <= operand_b;
`endif
                     if (special) begin
                        result_r <= pick(op, special_val);
                        done_r   <= 1'b1;
                        state    <= DONE;
`ifdef MULDIV_REUSE_EN
                        cache_a     <= operand_a;
                        cache_b     <= operand_b;
                        cache_cls   <= cls_of(op);
                        cache_val   <= special_val;
                        cache_valid <= 1'b1;
`endif
                     end
`ifdef MULDIV_REUSE_EN
                     else if (hit) begin
                        result_r <= pick(op, cache_val);
                        done_r   <= 1'b1;
                        state    <= DONE;
                     end
`endif
                     else begin
                        state <= BUSY;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end
               BUSY: begin
                  count <= count + 1'b1;
                  if (count == CW'(N - 1)) begin
                     acc      <= fin;
                     result_r <= pick(op_r, fin);
                     done_r   <= 1'b1;
                     state    <= DONE;
`ifdef MULDIV_REUSE_EN
                     cache_a     <= a_r;
                     cache_b     <= b_r;
                     cache_cls   <= cls_of(op_r);
                     cache_val   <= fin;
                     cache_valid <= 1'b1;
`endif
                  end else begin
                     acc <= step;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model predicts result and
// latency for every issued op into a queue, popped when done pulses.
module tb_muldiv_unit;
   localparam int DW  = 32;
   localparam int BPC = 1;
   localparam int N   = DW / BPC;
`ifdef MULDIV_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, flush;
   logic [2:0]    op;
   logic [DW-1:0] operand_a, operand_b;
   logic          in_ready, busy, done;
   logic [DW-1:0] result;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(DW), .BITS_PER_CYCLE(BPC)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
      .in_ready(in_ready), .busy(busy), .done(done), .result(result)
   );

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          passed = 0;
   logic        mdl_valid = 1'b0;
   logic [31:0] mdl_a = '0, mdl_b = '0;
   int          mdl_cls = 0;
   logic [31:0] last_res = '0;

   function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p, sa64, sb64, za64, zb64;
      logic        ovf;
      sa64 = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      za64 = {32'b0, a};
      zb64 = {32'b0, b};
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p    = '0;
      ref_op = '0;
      case (o)
         3'd0: begin p = za64 * zb64; ref_op = p[31:0];  end
         3'd1: begin p = sa64 * sb64; ref_op = p[63:32]; end
         3'd2: begin p = sa64 * zb64; ref_op = p[63:32]; end
         3'd3: begin p = za64 * zb64; ref_op = p[63:32]; end
         3'd4: ref_op = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: ref_op = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: ref_op = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int cls_of(input logic [2:0] o);
      case (o)
         3'd0, 3'd3: cls_of = 0;
         3'd1:       cls_of = 1;
         3'd2:       cls_of = 2;
         3'd4, 3'd6: cls_of = 3;
         default:    cls_of = 4;
      endcase
   endfunction

   task automatic predict(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   spec, hit;
      spec  = o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      hit   = REUSE && mdl_valid && (mdl_a == a) && (mdl_b == b) && (mdl_cls == cls_of(o));
      e.res = ref_op(o, a, b);
      e.lat = (spec || hit) ? 1 : N + 1;
      sb_q.push_back(e);
      mdl_valid = 1'b1;
      mdl_a     = a;
      mdl_b     = b;
      mdl_cls   = cls_of(o);
   endtask

   task automatic start_raw(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      predict(o, a, b);
      start_raw(o, a, b);
   endtask

   // lat counts cycles after the accept edge; 0 means the bound expired
   task automatic wait_done(output logic [31:0] r, output int lat);
      lat = 0;
      r   = '0;
      for (int c = 1; c <= 200 && lat == 0; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            r   = result;
            lat = c;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      checks++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0)     $display("FAIL reset_done got %b want 0", done); else passed++;
      checks++; if (result !== 32'h0)  $display("FAIL reset_result got %h want 0", result); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_vectors;
      logic [2:0]  vo[10];
      logic [31:0] va[10], vb[10], vx[10];
      logic [31:0] r;
      int          lat;
      exp_t        e;
      vo[0] = 3'd5; va[0] = 32'd100;        vb[0] = 32'd7;          vx[0] = 32'd14;
      vo[1] = 3'd7; va[1] = 32'd100;        vb[1] = 32'd7;          vx[1] = 32'd2;
      vo[2] = 3'd4; va[2] = 32'h8000_0000;  vb[2] = 32'hFFFF_FFFF;  vx[2] = 32'h8000_0000;
      vo[3] = 3'd6; va[3] = 32'h8000_0000;  vb[3] = 32'hFFFF_FFFF;  vx[3] = 32'h0;
      vo[4] = 3'd4; va[4] = 32'd5;          vb[4] = 32'd0;          vx[4] = 32'hFFFF_FFFF;
      vo[5] = 3'd6; va[5] = 32'd5;          vb[5] = 32'd0;          vx[5] = 32'd5;
      vo[6] = 3'd2; va[6] = 32'hFFFF_FFFF;  vb[6] = 32'd2;          vx[6] = 32'hFFFF_FFFF;
      vo[7] = 3'd3; va[7] = 32'hFFFF_FFFF;  vb[7] = 32'hFFFF_FFFF;  vx[7] = 32'hFFFF_FFFE;
      vo[8] = 3'd0; va[8] = 32'hFFFF_FFF9;  vb[8] = 32'd3;          vx[8] = 32'hFFFF_FFEB;
      vo[9] = 3'd1; va[9] = 32'h8000_0000;  vb[9] = 32'h8000_0000;  vx[9] = 32'h4000_0000;
      for (int i = 0; i < 26; i++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         if (i < 10) begin
            o = vo[i]; a = va[i]; b = vb[i];
         end else begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         end
         drive_op(o, a, b);
         wait_done(r, lat);
         e = sb_q.pop_front();
         checks++; if (r !== e.res) $display("FAIL vec%0d_result op=%0d got %h want %h", i, o, r, e.res); else passed++;
         checks++; if (lat !== e.lat) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, e.lat); else passed++;
         if (i < 10) begin
            checks++; if (r !== vx[i]) $display("FAIL vec%0d_const got %h want %h", i, r, vx[i]); else passed++;
         end
         last_res = e.res;
         @(negedge clk);
         checks++; if (done !== 1'b0) $display("FAIL vec%0d_done_pulse got %b want 0", i, done); else passed++;
      end
   endtask

   task automatic test_flush;
      logic [31:0] r;
      int          lat;
      exp_t        e;
      start_raw(3'd4, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      checks++; if (busy !== 1'b1)     $display("FAIL flush_busy_mid got %b want 1", busy); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready_mid got %b want 0", in_ready); else passed++;
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      mdl_valid = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  $display("FAIL flush_idle got %b want 1", in_ready); else passed++;
      checks++; if (busy !== 1'b0)      $display("FAIL flush_busy got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0)      $display("FAIL flush_done got %b want 0", done); else passed++;
      checks++; if (result !== last_res) $display("FAIL flush_result_kept got %h want %h", result, last_res); else passed++;
      drive_op(3'd5, 32'd9, 32'd3);
      wait_done(r, lat);
      e = sb_q.pop_front();
      checks++; if (r !== e.res || r !== 32'd3) $display("FAIL flush_next_result got %h want %h", r, e.res); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL flush_next_latency got %0d want %0d", lat, e.lat); else passed++;
      last_res = e.res;
   endtask

   task automatic test_back_to_back;
      logic [31:0] r1, r2;
      int          lat1, lat2;
      bit          busy_ok;
      logic        busy_at_done;
      exp_t        e;
      @(negedge clk);
      op = 3'd3; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
      predict(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      op = 3'd5; operand_a = 32'd100; operand_b = 32'd7;
      predict(3'd5, 32'd100, 32'd7);
      busy_ok = 1'b1; lat1 = 0; r1 = '0; busy_at_done = 1'b0;
      for (int c = 1; c <= 200 && lat1 == 0; c++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            r1 = result; lat1 = c; busy_at_done = busy;
         end
      end
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(r2, lat2);
      e = sb_q.pop_front();
      checks++; if (r1 !== e.res)   $display("FAIL b2b_first_result got %h want %h", r1, e.res); else passed++;
      checks++; if (lat1 !== e.lat) $display("FAIL b2b_first_latency got %0d want %0d", lat1, e.lat); else passed++;
      checks++; if (busy_ok !== 1'b1) $display("FAIL b2b_busy_held got %b want 1", busy_ok); else passed++;
      checks++; if (busy_at_done !== 1'b1) $display("FAIL b2b_busy_at_done got %b want 1", busy_at_done); else passed++;
      e = sb_q.pop_front();
      checks++; if (r2 !== e.res)   $display("FAIL b2b_second_result got %h want %h", r2, e.res); else passed++;
      checks++; if (lat2 !== e.lat) $display("FAIL b2b_second_latency got %0d want %0d", lat2, e.lat); else passed++;
      last_res = e.res;
   endtask

   task automatic test_reuse;
      logic [31:0] r;
      int          lat;
      exp_t        e;
      drive_op(3'd4, 32'hFFFF_FFEC, 32'd6);
      wait_done(r, lat);
      e = sb_q.pop_front();
      checks++; if (r !== 32'hFFFF_FFFD || r !== e.res) $display("FAIL reuse_div got %h want %h", r, e.res); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL reuse_div_latency got %0d want %0d", lat, e.lat); else passed++;
      drive_op(3'd6, 32'hFFFF_FFEC, 32'd6);
      wait_done(r, lat);
      e = sb_q.pop_front();
      checks++; if (r !== 32'hFFFF_FFFE || r !== e.res) $display("FAIL reuse_rem got %h want %h", r, e.res); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL reuse_rem_latency got %0d want %0d", lat, e.lat); else passed++;
      last_res = e.res;
   endtask

   task automatic test_reset_mid;
      int dones;
      start_raw(3'd5, 32'd50, 32'd5);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", in_ready); else passed++;
      checks++; if (busy !== 1'b0)     $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
      checks++; if (result !== 32'h0)  $display("FAIL rstmid_result got %h want 0", result); else passed++;
      @(negedge clk);
      rst = 1'b0;
      mdl_valid = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      checks++; if (dones !== 0) $display("FAIL rstmid_no_done got %0d want 0", dones); else passed++;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_flush();
      test_back_to_back();
      test_reuse();
      test_reset_mid();
      checks++; if (sb_q.size() !== 0) $display("FAIL scoreboard_empty got %0d want 0", sb_q.size()); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
